// File: rtl/nw_border_init_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : nw_border_init_sequencer_if
//  Purpose  : Bundles the enable/stall inputs and the two border write
//             channels of the Needleman-Wunsch border init sequencer.
//  Signals  : en_init, hit          -> towards the sequencer
//             row_we/row_addr,
//             col_we/col_addr,
//             data, busy, end_init  <- from the sequencer
//  Modports : master = sequencer side, slave = control FSM / memory side
//  Revision : 1.0  initial release
// ============================================================================
interface nw_border_init_sequencer_if #(
  parameter int BitAddr = 8,
  parameter int DATA_W  = 9
) ();
  logic                     en_init;
  logic                     hit;
  logic                     row_we;
  logic [BitAddr-1:0]       row_addr;
  logic                     col_we;
  logic [BitAddr-1:0]       col_addr;
  logic signed [DATA_W-1:0] data;
  logic                     busy;
  logic                     end_init;

  modport master (
    input  en_init, hit,
    output row_we, row_addr, col_we, col_addr, data, busy, end_init
  );

  modport slave (
    output en_init, hit,
    input  row_we, row_addr, col_we, col_addr, data, busy, end_init
  );
endinterface
`default_nettype wire

// File: rtl/nw_border_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nw_border_init_sequencer
//  Purpose  : Writes the gap-penalty border k*GAP_SCORE (k = 0..N), with
//             signed saturation, into the first row and first column of the
//             NW score-matrix RAM. Sequential (row then column) or dual
//             (both channels at once) mode, memory stall via hit, abort when
//             en_init drops, and a settle period before end_init.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             bus    - master modport: en_init/hit in; row/col write
//                      channels, data, busy, end_init out (all registered)
//  Revision : 1.0  initial release
// ============================================================================
module nw_border_init_sequencer #(
  parameter int N             = 128,
  parameter int BitAddr       = $clog2(N + 1),
  parameter int DATA_W        = 9,
  parameter int GAP_SCORE     = -2,
  parameter int DUAL          = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  nw_border_init_sequencer_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROW    = 3'd1,
    S_COL    = 3'd2,
    S_BOTH   = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Settle counter runs 0..SETTLE_CYCLES-1.
  localparam int                       CntW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0]          SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [BitAddr-1:0]       KLast      = BitAddr'(N);
  localparam logic [DATA_W:0]          GapExt     = (DATA_W + 1)'(GAP_SCORE);
  localparam logic [DATA_W-1:0]        MaxVal     = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0]        MinVal     = {1'b1, {(DATA_W - 1){1'b0}}};

  state_t                   state_q, state_d;
  logic [BitAddr-1:0]       k_q, k_d;
  logic [CntW-1:0]          settle_q, settle_d;
  logic                     row_we_q, row_we_d;
  logic                     col_we_q, col_we_d;
  logic [BitAddr-1:0]       row_addr_q, row_addr_d;
  logic [BitAddr-1:0]       col_addr_q, col_addr_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     end_init_q, end_init_d;

  logic [DATA_W:0]          sum;
  logic [DATA_W-1:0]        sat;
  logic [BitAddr-1:0]       k_next;
  logic                     go_idle;

  // One guard bit is enough to detect overflow of data + GAP_SCORE; when the
  // two top bits disagree the true result left the DATA_W range and the guard
  // bit carries its sign. With a constant-sign gap the clamp is sticky.
  always_comb begin
    sum = {data_q[DATA_W-1], data_q} + GapExt;
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat = sum[DATA_W] ? MinVal : MaxVal;
    end else begin
      sat = sum[DATA_W-1:0];
    end
  end

  assign k_next = k_q + BitAddr'(1);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    settle_d   = settle_q;
    row_we_d   = row_we_q;
    col_we_d   = col_we_q;
    row_addr_d = row_addr_q;
    col_addr_d = col_addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    end_init_d = end_init_q;
    go_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en_init) begin
          state_d    = (DUAL != 0) ? S_BOTH : S_ROW;
          k_d        = '0;
          data_d     = '0;
          row_addr_d = '0;
          col_addr_d = '0;
          row_we_d   = 1'b1;
          col_we_d   = (DUAL != 0);
          busy_d     = 1'b1;
        end
      end

      S_ROW, S_COL, S_BOTH: begin
        if (!bus.en_init) begin
          go_idle = 1'b1;
        end else if (!bus.hit) begin
          if (k_q != KLast) begin
            k_d    = k_next;
            data_d = sat;
            if (state_q != S_COL) row_addr_d = k_next;
            if (state_q != S_ROW) col_addr_d = k_next;
          end else if (state_q == S_ROW) begin
            // Column restarts from cell (0,0); it is deliberately rewritten.
            state_d    = S_COL;
            k_d        = '0;
            data_d     = '0;
            col_addr_d = '0;
            row_we_d   = 1'b0;
            col_we_d   = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            settle_d = '0;
            row_we_d = 1'b0;
            col_we_d = 1'b0;
          end
        end
        // hit = 1 with en_init = 1: everything holds and the write retries.
      end

      S_SETTLE: begin
        if (!bus.en_init) begin
          go_idle = 1'b1;
        end else if (settle_q == SettleLast) begin
          state_d    = S_DONE;
          end_init_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          settle_d = settle_q + CntW'(1);
        end
      end

      S_DONE: begin
        if (!bus.en_init) go_idle = 1'b1;
      end

      default: go_idle = 1'b1;
    endcase

    // Abort / return path: nothing from the previous run survives.
    if (go_idle) begin
      state_d    = S_IDLE;
      k_d        = '0;
      settle_d   = '0;
      row_we_d   = 1'b0;
      col_we_d   = 1'b0;
      row_addr_d = '0;
      col_addr_d = '0;
      data_d     = '0;
      busy_d     = 1'b0;
      end_init_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      settle_q   <= '0;
      row_we_q   <= 1'b0;
      col_we_q   <= 1'b0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      end_init_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      settle_q   <= settle_d;
      row_we_q   <= row_we_d;
      col_we_q   <= col_we_d;
      row_addr_q <= row_addr_d;
      col_addr_q <= col_addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      end_init_q <= end_init_d;
    end
  end

  assign bus.row_we   = row_we_q;
  assign bus.col_we   = col_we_q;
  assign bus.row_addr = row_addr_q;
  assign bus.col_addr = col_addr_q;
  assign bus.data     = data_q;
  assign bus.busy     = busy_q;
  assign bus.end_init = end_init_q;

endmodule
`default_nettype wire

// File: tb/tb_nw_border_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nw_border_init_sequencer
//  Purpose  : Self-checking bench for nw_border_init_sequencer. Three
//             instances (sequential DATA_W=9, dual DATA_W=9, sequential
//             DATA_W=3) share one en_init/hit stream; each is compared
//             every cycle against a slot-position reference model, plus a
//             hand-written vector table and corner-case sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nw_border_init_sequencer;

  localparam int TN     = 4;
  localparam int TBA    = $clog2(TN + 1);
  localparam int TGAP   = -2;
  localparam int TSET   = 2;

  logic clk;
  logic rst_n;
  logic en;
  logic hit;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nw_border_init_sequencer_if #(.BitAddr(TBA), .DATA_W(9)) bus_s ();
  nw_border_init_sequencer_if #(.BitAddr(TBA), .DATA_W(9)) bus_d ();
  nw_border_init_sequencer_if #(.BitAddr(TBA), .DATA_W(3)) bus_n ();

  assign bus_s.en_init = en;  assign bus_s.hit = hit;
  assign bus_d.en_init = en;  assign bus_d.hit = hit;
  assign bus_n.en_init = en;  assign bus_n.hit = hit;

  nw_border_init_sequencer #(.N(TN), .BitAddr(TBA), .DATA_W(9), .GAP_SCORE(TGAP),
                             .DUAL(0), .SETTLE_CYCLES(TSET))
    u_seq (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  nw_border_init_sequencer #(.N(TN), .BitAddr(TBA), .DATA_W(9), .GAP_SCORE(TGAP),
                             .DUAL(1), .SETTLE_CYCLES(TSET))
    u_dual (.clk(clk), .rst_n(rst_n), .bus(bus_d));
  nw_border_init_sequencer #(.N(TN), .BitAddr(TBA), .DATA_W(3), .GAP_SCORE(TGAP),
                             .DUAL(0), .SETTLE_CYCLES(TSET))
    u_narrow (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A run is a flat list of slots: W write slots (N+1 per channel, one or two
  // channels), then TSET settle slots; p is the current slot.
  typedef struct {
    bit active;
    bit done;
    int p;
  } mst_t;

  mst_t ms, md, mn;

  function automatic int nwrites(int n, bit dual);
    return dual ? (n + 1) : 2 * (n + 1);
  endfunction

  function automatic mst_t mstep(mst_t s, bit e, bit h, int n, bit dual);
    mst_t r = s;
    int   w = nwrites(n, dual);
    if (!s.active && !s.done) begin
      if (e) begin r.active = 1; r.p = 0; end
    end else if (s.done) begin
      if (!e) r.done = 0;
    end else if (!e) begin
      r.active = 0; r.p = 0;
    end else if (!(s.p < w && h)) begin
      r.p = s.p + 1;
      if (r.p == w + TSET) begin r.active = 0; r.done = 1; end
    end
    return r;
  endfunction

  function automatic int sat(int v, int dw);
    int lo = -(1 << (dw - 1));
    int hi = (1 << (dw - 1)) - 1;
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_model(string tag, mst_t s, int n, bit dual, int dw,
                             logic rwe, logic cwe, int raddr, int caddr,
                             int dat, logic bsy, logic endi);
    int  w = nwrites(n, dual);
    bit  erwe = 0, ecwe = 0;
    int  k = 0;
    if (s.active && s.p < w) begin
      k    = s.p % (n + 1);
      erwe = dual || (s.p <= n);
      ecwe = dual || (s.p > n);
    end
    chk({tag, ".row_we"},   int'(rwe),  int'(erwe));
    chk({tag, ".col_we"},   int'(cwe),  int'(ecwe));
    chk({tag, ".busy"},     int'(bsy),  int'(s.active));
    chk({tag, ".end_init"}, int'(endi), int'(s.done));
    if (erwe) chk({tag, ".row_addr"}, raddr, k);
    if (ecwe) chk({tag, ".col_addr"}, caddr, k);
    if (erwe || ecwe) chk({tag, ".data"}, dat, sat(k * TGAP, dw));
    if (!s.active && !s.done) chk({tag, ".idle_data"}, dat, 0);
  endtask

  task automatic check_all();
    check_model("seq", ms, TN, 0, 9, bus_s.row_we, bus_s.col_we, bus_s.row_addr,
                bus_s.col_addr, bus_s.data, bus_s.busy, bus_s.end_init);
    check_model("dual", md, TN, 1, 9, bus_d.row_we, bus_d.col_we, bus_d.row_addr,
                bus_d.col_addr, bus_d.data, bus_d.busy, bus_d.end_init);
    check_model("narrow", mn, TN, 0, 3, bus_n.row_we, bus_n.col_we, bus_n.row_addr,
                bus_n.col_addr, bus_n.data, bus_n.busy, bus_n.end_init);
  endtask

  // Inputs are applied 1 time unit after an edge; outputs sampled 1 after the next.
  task automatic step(bit e, bit h);
    en  = e;
    hit = h;
    @(posedge clk);
    #1;
    cyc++;
    ms = mstep(ms, e, h, TN, 0);
    md = mstep(md, e, h, TN, 1);
    mn = mstep(mn, e, h, TN, 0);
    check_all();
  endtask

  task automatic model_reset();
    ms = '{0, 0, 0};
    md = '{0, 0, 0};
    mn = '{0, 0, 0};
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en;
    bit hit;
    bit rwe;
    bit cwe;
    int addr;
    int data;
    bit busy;
    bit endi;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Sequential run, no stalls: edge i+1 for entry i.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, -2, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, -4, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3, -6, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, -8, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, -2, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, -4, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3, -6, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4, -8, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0, 1'b0};

    en    = 1'b0;
    hit   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.row_we",   int'(bus_s.row_we),   0);
    chk("reset.col_we",   int'(bus_s.col_we),   0);
    chk("reset.data",     int'(bus_s.data),     0);
    chk("reset.busy",     int'(bus_s.busy),     0);
    chk("reset.end_init", int'(bus_s.end_init), 0);
    chk("reset.row_addr", int'(bus_s.row_addr), 0);
    rst_n = 1'b1;

    // Table: sequential schedule, done hold, return to IDLE.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].hit);
      chk("tbl.row_we",   int'(bus_s.row_we),   int'(tbl[i].rwe));
      chk("tbl.col_we",   int'(bus_s.col_we),   int'(tbl[i].cwe));
      chk("tbl.busy",     int'(bus_s.busy),     int'(tbl[i].busy));
      chk("tbl.end_init", int'(bus_s.end_init), int'(tbl[i].endi));
      if (tbl[i].rwe) chk("tbl.row_addr", int'(bus_s.row_addr), tbl[i].addr);
      if (tbl[i].cwe) chk("tbl.col_addr", int'(bus_s.col_addr), tbl[i].addr);
      if (tbl[i].rwe || tbl[i].cwe) chk("tbl.data", int'(bus_s.data), tbl[i].data);
      if (i == 4) chk("narrow.sat_data", int'(bus_n.data), -4);
      if (i == 4) chk("dual.addr_match", int'(bus_d.col_addr), int'(bus_d.row_addr));
      if (i == 6) chk("dual.end_early", int'(bus_d.end_init), 0);
      if (i == 7) chk("dual.end_edge8", int'(bus_d.end_init), 1);
    end

    // Stall: hit on the two edges after addr 2 is presented.
    step(1, 0); step(1, 0); step(1, 0);
    chk("hit.addr_pre", int'(bus_s.row_addr), 2);
    step(1, 1);
    step(1, 1);
    chk("hit.row_we",   int'(bus_s.row_we),   1);
    chk("hit.row_addr", int'(bus_s.row_addr), 2);
    chk("hit.data",     int'(bus_s.data),     -4);
    for (int e = 6; e <= 14; e++) step(1, 0);
    chk("hit.end_14", int'(bus_s.end_init), 0);
    step(1, 0);
    chk("hit.end_15", int'(bus_s.end_init), 1);
    step(0, 0);

    // Abort in COL at edge 7, then restart.
    for (int e = 1; e <= 6; e++) step(1, 0);
    chk("abort.col_we_pre", int'(bus_s.col_we), 1);
    step(0, 0);
    chk("abort.col_we", int'(bus_s.col_we),   0);
    chk("abort.busy",   int'(bus_s.busy),     0);
    chk("abort.data",   int'(bus_s.data),     0);
    chk("abort.end",    int'(bus_s.end_init), 0);
    step(1, 0);
    chk("restart.row_we",   int'(bus_s.row_we),   1);
    chk("restart.row_addr", int'(bus_s.row_addr), 0);
    step(1, 0);
    step(0, 1);
    chk("abort_hit.busy",   int'(bus_s.busy),   0);
    chk("abort_hit.row_we", int'(bus_s.row_we), 0);
    step(0, 0);

    // Asynchronous reset mid-ROW: outputs clear before the next edge.
    step(1, 0); step(1, 0); step(1, 0);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    model_reset();
    chk("areset.row_we",   int'(bus_s.row_we),   0);
    chk("areset.row_addr", int'(bus_s.row_addr), 0);
    chk("areset.data",     int'(bus_s.data),     0);
    chk("areset.busy",     int'(bus_s.busy),     0);
    chk("areset.dual_we",  int'(bus_d.col_we),   0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Randomised stream against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
